gpio_in_filter: RTL



---
 rtl/gpio_in_filter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/gpio_in_filter.sv
// GPIO pad input conditioning: two-flop synchronizer, per-bit debounce, optional edge-to-IRQ logic.
// Optional feature macro: GPIO_FILT_IRQ_EN (IRQ_EN/RISE_SEL/FALL_SEL/PEND registers and irq_o).
module gpio_in_filter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    input  logic             we_i,
    input  logic             re_i,
    output logic [31:0]      rdata_o,
    input  logic [WIDTH-1:0] gpio_pad_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic             irq_o
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    localparam logic [2:0] A_FILT     = 3'd0;
    localparam logic [2:0] A_IRQ_EN   = 3'd1;
    localparam logic [2:0] A_RISE_SEL = 3'd2;
    localparam logic [2:0] A_FALL_SEL = 3'd3;
    localparam logic [2:0] A_PEND     = 3'd4;
    localparam logic [2:0] A_RAW      = 3'd5;

    logic [WIDTH-1:0]            sync1_q, sync2_q;
    logic [WIDTH-1:0]            filt_q, filt_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]                 rdata_q, rdata_d;
    logic [2:0]                  sel;
    logic [WIDTH-1:0]            wdata_w;
    logic                        unused_bits;

    assign sel         = addr_i[4:2];
    assign wdata_w     = wdata_i[WIDTH-1:0];
    assign unused_bits = ^{addr_i[31:5], addr_i[1:0], wdata_i, we_i};

    // Per-bit debounce: filt follows sync2 only after DEBOUNCE consecutive mismatches
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            sync1_q <= gpio_pad_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef GPIO_FILT_IRQ_EN
    logic [WIDTH-1:0] irq_en_q, irq_en_d;
    logic [WIDTH-1:0] rise_sel_q, rise_sel_d;
    logic [WIDTH-1:0] fall_sel_q, fall_sel_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] pend_set, pend_clr;

    // Edge capture into PEND; a same-cycle set beats a W1C clear
    always_comb begin
        irq_en_d   = irq_en_q;
        rise_sel_d = rise_sel_q;
        fall_sel_d = fall_sel_q;
        pend_clr   = '0;
        pend_set   = (filt_d & ~filt_q & rise_sel_q) | (~filt_d & filt_q & fall_sel_q);
        if (we_i) begin
            case (sel)
                A_IRQ_EN:   irq_en_d   = wdata_w;
                A_RISE_SEL: rise_sel_d = wdata_w;
                A_FALL_SEL: fall_sel_d = wdata_w;
                A_PEND:     pend_clr   = wdata_w;
                default:    ;
            endcase
        end
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_q   <= '0;
            rise_sel_q <= '0;
            fall_sel_q <= '0;
            pend_q     <= '0;
        end else begin
            irq_en_q   <= irq_en_d;
            rise_sel_q <= rise_sel_d;
            fall_sel_q <= fall_sel_d;
            pend_q     <= pend_d;
        end
    end

    assign irq_o = |(pend_q & irq_en_q);
`else
    assign irq_o = 1'b0;
`endif

    // Read mux returns pre-write register values
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = '0;
            case (sel)
                A_FILT:     rdata_d = 32'(filt_q);
                A_RAW:      rdata_d = 32'(sync2_q);
`ifdef GPIO_FILT_IRQ_EN
                A_IRQ_EN:   rdata_d = 32'(irq_en_q);
                A_RISE_SEL: rdata_d = 32'(rise_sel_q);
                A_FALL_SEL: rdata_d = 32'(fall_sel_q);
                A_PEND:     rdata_d = 32'(pend_q);
`endif
                default:    rdata_d = '0;
            endcase
        end
    end

    assign gpio_o  = filt_q;
    assign rdata_o = rdata_q;

endmodule
